// File: rtl/fsmm_drv.sv
// fsmm_drv: drives a five-state Mealy controller (S0..S4) to a requested target
// state along a fixed route, mirrors the controller state, and checks the m/n
// outputs the controller returns against the protocol table.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   req, tgt       move request and target state (0..4 valid)
//   m, n           Mealy outputs returned by the driven controller
//   a, b           combinational stimulus to the controller
//   busy           move in progress
//   done, nak      one-cycle pulses: move completed / request rejected
//   hops           transitions taken by the last or current move
//   err, err_cnt   sticky m/n mismatch flag and saturating mismatch count
module fsmm_drv (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [2:0] tgt,
   input  logic       m,
   input  logic       n,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       nak,
   output logic [2:0] hops,
   output logic       err,
   output logic [7:0] err_cnt
);

   localparam int unsigned StW   = 3;
   localparam int unsigned CntW  = 8;
   localparam logic [StW-1:0]  GoalPark = StW'(7);
   localparam logic [StW-1:0]  TgtMax   = StW'(4);
   localparam logic [CntW-1:0] CntMax   = CntW'(255);

   typedef enum logic [StW-1:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } st_e;

   // Protocol table: returns {next_state, m, n} for (state, a, b).
   function automatic logic [4:0] step(input st_e s, input logic [1:0] ab);
      logic [4:0] r;
      case (s)
         S0:      r = (ab[1] == 1'b0) ? {3'd0, 2'b00} :
                      (ab[0] == 1'b1) ? {3'd4, 2'b10} : {3'd1, 2'b01};
         S1:      r = {3'd2, 2'b11};
         S2:      r = ab[1] ? {3'd3, 2'b10} : {3'd4, 2'b01};
         S3: begin
            case (ab)
               2'b01:   r = {3'd3, 2'b11};
               2'b10:   r = {3'd0, 2'b11};
               2'b11:   r = {3'd4, 2'b00};
               default: r = {3'd3, 2'b00}; // never driven
            endcase
         end
         S4:      r = ab[0] ? {3'd1, 2'b11} : {3'd4, 2'b01};
         default: r = {3'd0, 2'b00};
      endcase
      return r;
   endfunction

   // Route drive: one row per goal, fields ordered S0..S4 of current state.
   function automatic logic [1:0] route(input logic [StW-1:0] g, input st_e s);
      logic [9:0] row;
      logic [1:0] r;
      case (g)
         3'd0:    row = 10'b00_00_10_10_01;
         3'd1:    row = 10'b10_00_00_11_01;
         3'd2:    row = 10'b10_00_00_11_01;
         3'd3:    row = 10'b10_00_10_01_01;
         3'd4:    row = 10'b11_00_00_11_00;
         default: row = 10'b00_00_00_01_00; // park
      endcase
      case (s)
         S0:      r = row[9:8];
         S1:      r = row[7:6];
         S2:      r = row[5:4];
         S3:      r = row[3:2];
         default: r = row[1:0];
      endcase
      return r;
   endfunction

   st_e             st_q, st_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            nak_q, nak_d;
   logic [StW-1:0]  hops_q, hops_d;
   logic [StW-1:0]  tgt_r_q, tgt_r_d;
   logic            err_q, err_d;
   logic [CntW-1:0] err_cnt_q, err_cnt_d;

   logic            accept;
   logic [StW-1:0]  goal;
   logic [1:0]      ab;
   logic [4:0]      stp;
   st_e             nxt_st;
   logic            mismatch;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q      <= S0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         nak_q     <= 1'b0;
         hops_q    <= '0;
         tgt_r_q   <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         st_q      <= st_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         nak_q     <= nak_d;
         hops_q    <= hops_d;
         tgt_r_q   <= tgt_r_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // Goal selection, route drive, move control and m/n checker
   always_comb begin
      st_d      = st_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      nak_d     = 1'b0;
      hops_d    = hops_q;
      tgt_r_d   = tgt_r_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      goal      = GoalPark;

      accept = !busy_q && req && (tgt <= TgtMax);

      // A zero-move accept (already at target) keeps the park drive.
      if (busy_q) begin
         goal = tgt_r_q;
      end else if (accept && (tgt != StW'(st_q))) begin
         goal = tgt;
      end

      ab     = route(goal, st_q);
      stp    = step(st_q, ab);
      nxt_st = st_e'(stp[4:2]);
      st_d   = nxt_st;

      if (busy_q) begin
         hops_d = StW'(hops_q + StW'(1));
         if (StW'(nxt_st) == tgt_r_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end else if (accept) begin
         tgt_r_d = tgt;
         done_d  = 1'b1;
         hops_d  = '0;
         if (tgt != StW'(st_q)) begin
            // The accept cycle already takes the first transition.
            hops_d = StW'(1);
            if (StW'(nxt_st) != tgt) begin
               busy_d = 1'b1;
               done_d = 1'b0;
            end
         end
      end else if (req) begin
         nak_d = 1'b1;
      end

      mismatch = ({m, n} != stp[1:0]);
      if (mismatch) begin
         err_d = 1'b1;
         if (err_cnt_q != CntMax) begin
            err_cnt_d = CntW'(err_cnt_q + CntW'(1));
         end
      end
   end

   assign a       = rst ? 1'b0 : ab[1];
   assign b       = rst ? 1'b0 : ab[0];
   assign busy    = busy_q;
   assign done    = done_q;
   assign nak     = nak_q;
   assign hops    = hops_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_fsmm_drv.sv
// tb_fsmm_drv: directed bench for fsmm_drv with a behavioural model of the
// driven controller and a scoreboard of expected move results.
module tb_fsmm_drv;

   logic       clk, rst, req, m, n, a, b, busy, done, nak, err;
   logic [2:0] tgt, hops;
   logic [7:0] err_cnt;

   logic       force_m;
   logic [2:0] ctl_st;
   logic [4:0] ctl_r;

   typedef struct packed {
      logic [2:0] hops;
      logic [2:0] st;
   } sb_t;

   sb_t sb[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   fsmm_drv dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .tgt     (tgt),
      .m       (m),
      .n       (n),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .nak     (nak),
      .hops    (hops),
      .err     (err),
      .err_cnt (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Controller model: {next_state, m, n}
   function automatic logic [4:0] ctl_step(input logic [2:0] s, input logic ia, input logic ib);
      logic [4:0] r;
      case (s)
         3'd0: begin
            if (!ia)    r = {3'd0, 2'b00};
            else if (ib) r = {3'd4, 2'b10};
            else        r = {3'd1, 2'b01};
         end
         3'd1: r = {3'd2, 2'b11};
         3'd2: r = ia ? {3'd3, 2'b10} : {3'd4, 2'b01};
         3'd3: begin
            if (!ia && ib)      r = {3'd3, 2'b11};
            else if (ia && !ib) r = {3'd0, 2'b11};
            else if (ia && ib)  r = {3'd4, 2'b00};
            else                r = {3'd3, 2'b00};
         end
         3'd4: r = ib ? {3'd1, 2'b11} : {3'd4, 2'b01};
         default: r = {3'd0, 2'b00};
      endcase
      return r;
   endfunction

   always_comb ctl_r = ctl_step(ctl_st, a, b);
   assign m = ctl_r[1] ^ force_m;
   assign n = ctl_r[0];
   always_ff @(posedge clk) ctl_st <= rst ? 3'd0 : ctl_r[4:2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the combinational drive for the current inputs, then advance a cycle.
   task automatic drive(input string tag, input logic [1:0] exp_ab);
      #1;
      chk(tag, 32'({a, b}), 32'(exp_ab));
      tick();
   endtask

   // Wait (bounded) for done, compare against the scoreboard head, check pulse width.
   task automatic wait_done(input string tag, input int budget);
      sb_t e;
      int  i = 0;
      while (done !== 1'b1 && i < budget) begin
         tick();
         i++;
      end
      chk({tag, "_done"}, 32'(done), 32'(1));
      chk({tag, "_idle"}, 32'(busy), 32'(0));
      chk({tag, "_sbdepth"}, 32'(sb.size()), 32'(1));
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_hops"}, 32'(hops), 32'(e.hops));
         chk({tag, "_st"}, 32'(ctl_st), 32'(e.st));
      end
      tick();
      chk({tag, "_pulse"}, 32'(done), 32'(0));
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; tgt = 3'd0; force_m = 1'b0;
      tick();
      #1 chk("rst_ab", 32'({a, b}), 32'(0));
      tick();
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_nak", 32'(nak), 32'(0));
      chk("rst_hops", 32'(hops), 32'(0));
      chk("rst_err", 32'(err), 32'(0));
      chk("rst_cnt", 32'(err_cnt), 32'(0));
      rst = 1'b0;

      // S0 -> S3
      sb.push_back(sb_t'{3'd3, 3'd3});
      req = 1'b1; tgt = 3'd3;
      drive("m1_ab0", 2'b10);
      req = 1'b0;
      chk("m1_busy", 32'(busy), 32'(1));
      drive("m1_ab1", 2'b00);
      drive("m1_ab2", 2'b10);
      wait_done("m1", 4);
      chk("m1_err", 32'(err), 32'(0));

      // S3 -> S0 in one hop
      sb.push_back(sb_t'{3'd1, 3'd0});
      req = 1'b1; tgt = 3'd0;
      drive("m2_ab", 2'b10);
      req = 1'b0;
      wait_done("m2", 2);

      // Invalid target while idle
      req = 1'b1; tgt = 3'd5;
      drive("nak_ab", 2'b00);
      req = 1'b0;
      chk("nak_pulse", 32'(nak), 32'(1));
      chk("nak_busy", 32'(busy), 32'(0));
      chk("nak_hops", 32'(hops), 32'(1));
      chk("nak_st", 32'(ctl_st), 32'(0));
      tick();
      chk("nak_once", 32'(nak), 32'(0));

      // S0 -> S4
      sb.push_back(sb_t'{3'd1, 3'd4});
      req = 1'b1; tgt = 3'd4;
      drive("m3_ab", 2'b11);
      req = 1'b0;
      wait_done("m3", 2);

      // S4 -> S2 with a second request while busy
      sb.push_back(sb_t'{3'd2, 3'd2});
      req = 1'b1; tgt = 3'd2;
      drive("m4_ab0", 2'b01);
      tgt = 3'd0;
      drive("m4_ab1", 2'b00);
      req = 1'b0;
      chk("m4_nonak", 32'(nak), 32'(0));
      wait_done("m4", 2);
      chk("park_s4", 32'(ctl_st), 32'(4));

      // Zero-move at S4
      sb.push_back(sb_t'{3'd0, 3'd4});
      req = 1'b1; tgt = 3'd4;
      drive("z_ab", 2'b00);
      req = 1'b0;
      wait_done("z", 1);

      // S4 -> S0, four hops, one cycle of forced m mismatch
      sb.push_back(sb_t'{3'd4, 3'd0});
      req = 1'b1; tgt = 3'd0;
      drive("m5_ab0", 2'b01);
      req = 1'b0;
      force_m = 1'b1;
      drive("m5_ab1", 2'b00);
      force_m = 1'b0;
      drive("m5_ab2", 2'b10);
      chk("m5_busy", 32'(busy), 32'(1));
      drive("m5_ab3", 2'b10);
      wait_done("m5", 2);
      chk("m5_err", 32'(err), 32'(1));
      chk("m5_cnt", 32'(err_cnt), 32'(1));

      // Saturation
      force_m = 1'b1;
      repeat (300) tick();
      chk("sat_cnt", 32'(err_cnt), 32'(255));
      force_m = 1'b0;
      tick();
      chk("sat_hold", 32'(err_cnt), 32'(255));
      chk("sat_err", 32'(err), 32'(1));

      // Reset mid-move
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("r_err", 32'(err), 32'(0));
      chk("r_cnt", 32'(err_cnt), 32'(0));
      req = 1'b1; tgt = 3'd3;
      drive("r_ab0", 2'b10);
      req = 1'b0;
      chk("r_busy1", 32'(busy), 32'(1));
      rst = 1'b1;
      drive("r_ab1", 2'b00);
      rst = 1'b0;
      chk("r_busy0", 32'(busy), 32'(0));
      chk("r_nodone", 32'(done), 32'(0));
      chk("r_hops", 32'(hops), 32'(0));
      chk("r_st", 32'(ctl_st), 32'(0));
      tick();
      chk("r_nodone2", 32'(done), 32'(0));
      sb.push_back(sb_t'{3'd1, 3'd4});
      req = 1'b1; tgt = 3'd4;
      drive("r_ab2", 2'b11);
      req = 1'b0;
      wait_done("r", 2);
      chk("sb_left", 32'(sb.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fsmm_drv.md
FSMM_DRV -- requirements
Module: fsmm_drv

Interface
REQ-001 The block SHALL have the following ports:
 clk      in   1  single clock, all state updates on rising edge
 rst      in   1  synchronous, active-high reset
 req      in   1  move request, sampled only when busy=0
 tgt      in   3  requested target state, encoded 0..4 as S0..S4
 m        in   1  Mealy output m returned by the driven controller
 n        in   1  Mealy output n returned by the driven controller
 a        out  1  stimulus a to the controller, combinational
 b        out  1  stimulus b to the controller, combinational
 busy     out  1  move in progress
 done     out  1  one-cycle pulse: move completed
 nak      out  1  one-cycle pulse: request rejected
 hops     out  3  transitions taken by the last or current move
 err      out  1  sticky m/n mismatch flag
 err_cnt  out  8  mismatch count, saturating
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-003 The block SHALL keep a mirror state st (S0..S4) of the driven controller. Each cycle st <= next(st,a,b) per the protocol table below.
REQ-004 Protocol table (current state, a b -> next state / m n):
- S0: a=0 -> S0/00; 11 -> S4/10; 10 -> S1/01.
- S1: any -> S2/11.
- S2: a=1 -> S3/10; a=0 -> S4/01.
- S3: 01 -> S3/11; 10 -> S0/11; 11 -> S4/00; 00 is never driven.
- S4: b=0 -> S4/01; b=1 -> S1/11.
REQ-005 Goal selection: goal = tgt_r if busy; tgt if req=1 with a valid tgt while idle; PARK otherwise.
REQ-006 Route drive (a b) per goal, listed for current S0/S1/S2/S3/S4:
- S0: 00/00/10/10/01
- S1: 10/00/00/11/01
- S2: 10/00/00/11/01
- S3: 10/00/10/01/01
- S4: 11/00/00/11/00
- PARK: 00/00/00/01/00
REQ-007 Idle accept: when busy=0, req=1 and tgt<=4, tgt SHALL be captured into tgt_r and hops cleared to 0.
- If st/=tgt: busy=1 from the next cycle; the route drive applies in the accept cycle itself.
- If st==tgt: zero-move completion; done=1 next cycle, hops=0, busy stays 0, and the accept-cycle drive is PARK.
REQ-008 While busy, each cycle SHALL increment hops. When next(st,a,b)==tgt_r, busy SHALL clear and done SHALL pulse in the following cycle.
REQ-009 A move SHALL take at most 4 transitions. busy SHALL never exceed 4 consecutive cycles.
REQ-010 req with tgt>4 while idle SHALL pulse nak for one cycle next cycle; no other state changes.
REQ-011 req while busy SHALL be ignored, with no nak and no change to tgt_r.
REQ-012 Checker: every cycle with rst=0, {m,n} SHALL be compared with the table value for (st,a,b). On a mismatch, err <= 1 (sticky until reset) and err_cnt increments, saturating at 255. The checker does not alter routing.

Reset
REQ-013 With rst=1 at a clock edge, the block SHALL set st=S0, busy=0, done=0, nak=0, hops=0, tgt_r=0, err=0, err_cnt=0. While rst=1, a=b=0.
REQ-014 Reset mid-move SHALL abort the move with no done pulse; operation resumes from S0 the cycle after rst deasserts.
REQ-015 The block SHALL assume the driven controller is reset on the same cycles.

Verification
REQ-016 Reset, then req with tgt=3 from S0 -> a b = 10, 00, 10 on consecutive cycles; st S1, S2, S3; done pulses once; hops=3; err=0.
REQ-017 From S3, req with tgt=0 -> a b = 10; one hop; done next cycle; st S0.
REQ-018 Idle in S0, req with tgt=5 -> nak for one cycle; busy=0; st stays S0; hops unchanged.
REQ-019 From S4, req with tgt=2, and a second req with tgt=0 one cycle later -> route S4->S1->S2 (01, 00); the second req is ignored; done once; hops=2.
REQ-020 Force m inverted for exactly one cycle during a move -> err=1 and err_cnt=1 thereafter; 300 forced cycles -> err_cnt=255.
REQ-021 Assert rst during the second hop of a tgt=3 move -> busy=0, st=S0, no done; a subsequent req with tgt=4 completes in 1 hop (a b = 11).
